// File: rtl/arm_hazard_pkg.sv
// Shared hazard-unit definitions: forwarding selects, shadow stage record, PC register index.
// Used by the hazard controller and by the execute-stage operand muxes.
package arm_hazard_pkg;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] wa3;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic [3:0] ra1;
        logic [3:0] ra2;
    } stage_rec_t;

    localparam stage_rec_t BUBBLE = '0;

    // The younger (M) producer wins over W; the PC is never forwarded.
    function automatic fwd_sel_t fwd_sel(input logic [3:0] src,
                                         input stage_rec_t m,
                                         input stage_rec_t w);
        if (src == REG_PC)                            return FWD_REG;
        if (m.valid && m.reg_write && m.wa3 == src)   return FWD_MEM;
        if (w.valid && w.reg_write && w.wa3 == src)   return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard inputs and pipeline-control outputs of the hazard controller.
// Purely combinational bundle; no flow control of its own.
interface hazard_ctrl_if;
    logic [3:0]  RA1D;
    logic [3:0]  RA2D;
    logic [3:0]  WA3D;
    logic        RegWriteD;
    logic        MemToRegD;
    logic        PCSrcD;
    logic        BranchTakenE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [15:0] StallCount;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemToRegD, PCSrcD, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemToRegD, PCSrcD, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );
endinterface

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline record: bubble beats load, otherwise hold. One-cycle latency.
// Synchronous reset empties the stage.
module hazard_stage_reg
    import arm_hazard_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       bubble_i,
    input  stage_rec_t rec_i,
    output stage_rec_t rec_o
);

    stage_rec_t rec_q;
    stage_rec_t rec_d;

    always_comb begin
        rec_d = rec_q;
        if (bubble_i) begin
            rec_d = BUBBLE;
        end else if (load_i) begin
            rec_d = rec_i;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            rec_q <= BUBBLE;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, PC-write and branch flushes.
// Controls are zero-latency from decode inputs and shadow E/M/W state; all outputs forced to 0 in reset.
module hazard_ctrl
    import arm_hazard_pkg::*;
(
    input  logic         Clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    stage_rec_t d_rec;
    stage_rec_t e_q;
    stage_rec_t m_q;
    stage_rec_t w_q;

    logic        ldr_stall;
    logic        pc_pend;
    logic        stall_d;
    logic        stall_f;
    logic        flush_d;
    logic        flush_e;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    fwd_sel_t    fwd_a;
    fwd_sel_t    fwd_b;

    always_comb begin
        d_rec            = BUBBLE;
        d_rec.valid      = 1'b1;
        d_rec.wa3        = hz.WA3D;
        d_rec.reg_write  = hz.RegWriteD;
        d_rec.mem_to_reg = hz.MemToRegD;
        d_rec.pc_src     = hz.PCSrcD;
        d_rec.ra1        = hz.RA1D;
        d_rec.ra2        = hz.RA2D;
    end

    hazard_stage_reg u_stage_e (
        .Clk      (Clk),
        .reset    (reset),
        .load_i   (~stall_d),
        .bubble_i (flush_e),
        .rec_i    (d_rec),
        .rec_o    (e_q)
    );

    hazard_stage_reg u_stage_m (
        .Clk      (Clk),
        .reset    (reset),
        .load_i   (1'b1),
        .bubble_i (1'b0),
        .rec_i    (e_q),
        .rec_o    (m_q)
    );

    hazard_stage_reg u_stage_w (
        .Clk      (Clk),
        .reset    (reset),
        .load_i   (1'b1),
        .bubble_i (1'b0),
        .rec_i    (m_q),
        .rec_o    (w_q)
    );

    // A taken branch squashes the stalled instruction anyway, so it overrides the load-use stall.
    assign ldr_stall = e_q.valid && e_q.mem_to_reg && e_q.reg_write &&
                       ((hz.RA1D == e_q.wa3) || (hz.RA2D == e_q.wa3));
    assign pc_pend   = hz.PCSrcD || e_q.pc_src || m_q.pc_src;
    assign stall_d   = ldr_stall && !hz.BranchTakenE;
    assign stall_f   = (ldr_stall || pc_pend) && !hz.BranchTakenE;
    assign flush_e   = ldr_stall || hz.BranchTakenE;
    assign flush_d   = pc_pend || w_q.pc_src || hz.BranchTakenE;
    assign fwd_a     = fwd_sel(e_q.ra1, m_q, w_q);
    assign fwd_b     = fwd_sel(e_q.ra2, m_q, w_q);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.ForwardAE  = reset ? FWD_REG : fwd_a;
    assign hz.ForwardBE  = reset ? FWD_REG : fwd_b;
    assign hz.StallF     = !reset && stall_f;
    assign hz.StallD     = !reset && stall_d;
    assign hz.FlushD     = !reset && flush_d;
    assign hz.FlushE     = !reset && flush_e;
    assign hz.StallCount = reset ? 16'd0 : stall_cnt_q;

    logic unused_w_bits;
    assign unused_w_bits = ^{w_q.mem_to_reg, w_q.ra1, w_q.ra2};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against an instruction-level pipeline model.
module tb_hazard_ctrl;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .Clk   (Clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        bit v;
        int wa;
        bit rw;
        bit mr;
        bit pc;
        int ra1;
        int ra2;
    } instr_t;

    instr_t pipe [3];        // 0 = execute, 1 = memory, 2 = writeback
    int     model_cnt;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic expect_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int fwd_of(int src);
        if (src == 15) return 0;
        if (pipe[1].v && pipe[1].rw && pipe[1].wa == src) return 2;
        if (pipe[2].v && pipe[2].rw && pipe[2].wa == src) return 1;
        return 0;
    endfunction

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    // One clock: drive decode inputs, check every output, then advance the model across the edge.
    task automatic step(input int ra1, input int ra2, input int wa3, input bit rw,
                        input bit mr, input bit pcs, input bit bt, input bit rst);
        bit ldr, pend, e_sd, e_sf, e_fd, e_fe;
        int e_fa, e_fb, e_cnt;
        instr_t d;
        @(negedge Clk);
        reset           = rst;
        hz.RA1D         = 4'(ra1);
        hz.RA2D         = 4'(ra2);
        hz.WA3D         = 4'(wa3);
        hz.RegWriteD    = rw;
        hz.MemToRegD    = mr;
        hz.PCSrcD       = pcs;
        hz.BranchTakenE = bt;
        #1;
        ldr  = pipe[0].v && pipe[0].mr && pipe[0].rw && (ra1 == pipe[0].wa || ra2 == pipe[0].wa);
        pend = pcs || pipe[0].pc || pipe[1].pc;
        e_sd = ldr && !bt;
        e_sf = (ldr || pend) && !bt;
        e_fe = ldr || bt;
        e_fd = pend || pipe[2].pc || bt;
        e_fa = fwd_of(pipe[0].ra1);
        e_fb = fwd_of(pipe[0].ra2);
        e_cnt = model_cnt;
        if (rst) begin
            {e_sd, e_sf, e_fe, e_fd} = 4'b0;
            e_fa = 0; e_fb = 0; e_cnt = 0;
        end
        expect_eq("ForwardAE",  16'(hz.ForwardAE), 16'(e_fa));
        expect_eq("ForwardBE",  16'(hz.ForwardBE), 16'(e_fb));
        expect_eq("StallF",     16'(hz.StallF),    16'(e_sf));
        expect_eq("StallD",     16'(hz.StallD),    16'(e_sd));
        expect_eq("FlushD",     16'(hz.FlushD),    16'(e_fd));
        expect_eq("FlushE",     16'(hz.FlushE),    16'(e_fe));
        expect_eq("StallCount", hz.StallCount,     16'(e_cnt));
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = bubble();
            model_cnt = 0;
        end else begin
            if (e_sd && model_cnt < 65535) model_cnt++;
            d = '{v: 1, wa: wa3, rw: rw, mr: mr, pc: pcs, ra1: ra1, ra2: ra2};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_fe)       pipe[0] = bubble();
            else if (!e_sd) pipe[0] = d;
        end
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 15 : r;
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        model_cnt = 0;

        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(7, 7, 7, 1, 1, 1, 1, 1);
        expect_eq("reset_cnt", hz.StallCount, 16'd0);

        // Forward from M
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 4, 5, 0, 0, 0, 0, 0);
        nop();
        expect_eq("fwdM_A", 16'(hz.ForwardAE), 16'd2);
        expect_eq("fwdM_B", 16'(hz.ForwardBE), 16'd0);

        // Two producers of R2: younger M copy wins; with a gap, W forwards
        step(0, 0, 2, 1, 0, 0, 0, 0);
        step(0, 0, 2, 1, 0, 0, 0, 0);
        step(5, 2, 6, 0, 0, 0, 0, 0);
        nop();
        expect_eq("fwdPrio_B", 16'(hz.ForwardBE), 16'd2);
        step(0, 0, 2, 1, 0, 0, 0, 0);
        nop();
        step(5, 2, 6, 0, 0, 0, 0, 0);
        nop();
        expect_eq("fwdW_B", 16'(hz.ForwardBE), 16'd1);

        // Load-use
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 3, 1, 1, 0, 0, 0);
        step(3, 0, 4, 1, 0, 0, 0, 0);
        expect_eq("ldr_stallD", 16'(hz.StallD), 16'd1);
        expect_eq("ldr_flushE", 16'(hz.FlushE), 16'd1);
        step(3, 0, 4, 1, 0, 0, 0, 0);
        expect_eq("ldr_once", 16'(hz.StallD), 16'd0);
        expect_eq("ldr_cnt", hz.StallCount, 16'd1);
        nop();
        expect_eq("ldr_fwdW", 16'(hz.ForwardAE), 16'd1);

        // Branch beats load-use
        step(0, 0, 3, 1, 1, 0, 0, 0);
        step(3, 0, 4, 1, 0, 0, 1, 0);
        expect_eq("br_stallF", 16'(hz.StallF), 16'd0);
        expect_eq("br_flushD", 16'(hz.FlushD), 16'd1);
        expect_eq("br_cnt", hz.StallCount, 16'd1);

        // PC write: FlushD for 4 cycles, StallF for 3; R15 source never forwards
        step(0, 0, 15, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(15, 15, 0, 0, 0, 0, 0, 0);
            expect_eq("pc_flushD", 16'(hz.FlushD), 16'd1);
            expect_eq("pc_stallF", 16'(hz.StallF), (i < 3) ? 16'd1 : 16'd0);
        end
        nop();
        expect_eq("pc_done", 16'(hz.FlushD), 16'd0);
        expect_eq("pc_nofwd", 16'(hz.ForwardAE), 16'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step(rnd_reg(), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) == 0));
        end

        // Saturation: preload the counter just below the limit, then keep stalling
        nop();
        nop();
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        model_cnt = 16'hFFFD;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 9, 1, 1, 0, 0, 0);
            step(9, 0, 9, 1, 1, 0, 0, 0);
        end
        nop();
        expect_eq("sat_cnt", hz.StallCount, 16'hFFFF);
        step(0, 0, 9, 1, 1, 0, 0, 0);
        step(9, 9, 9, 1, 1, 1, 1, 1);
        expect_eq("rst_stallF", 16'(hz.StallF), 16'd0);
        expect_eq("rst_flushD", 16'(hz.FlushD), 16'd0);
        step(9, 9, 1, 0, 0, 0, 0, 0);
        expect_eq("post_rst_cnt", hz.StallCount, 16'd0);
        expect_eq("post_rst_stall", 16'(hz.StallD), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on rising Clk.
REQ-003 SHALL have port RA1D, RA2D, input, 4 each: source register addresses of the instruction in decode.
REQ-004 SHALL have port WA3D, input, 4: destination register of the instruction in decode.
REQ-005 SHALL have port RegWriteD, MemToRegD, PCSrcD, input, 1 each: decode write-enable, load flag, and PC-write flag.
REQ-006 SHALL have port BranchTakenE, input, 1: the branch in execute resolved taken this cycle.
REQ-007 SHALL have port ForwardAE, ForwardBE, output, 2 each: execute operand select; 00 = register file, 01 = ResultW, 10 = ALUResultM.
REQ-008 SHALL have port StallF, StallD, FlushD, FlushE, output, 1 each: pipeline register controls.
REQ-009 SHALL have port StallCount, output, 16: count of cycles with StallD high.

Function
REQ-010 SHALL keep shadow stage records E, M, W, each holding {valid, WA3, RegWrite, MemToReg, PCSrc}; E additionally holds RA1, RA2.
REQ-011 Each cycle SHALL advance W<=M and M<=E.
- E<=D record (valid=1) when not StallD and not FlushE.
- E<=bubble (valid=0, all flags 0) when FlushE.
- E holds when StallD and not FlushE.
REQ-012 ForwardAE SHALL be 10 if E.RA1==M.WA3 and M.RegWrite and M.valid; else 01 if E.RA1==W.WA3 and W.RegWrite and W.valid; else 00. M has priority over W.
REQ-013 ForwardBE SHALL follow REQ-012 with E.RA2.
REQ-014 Address 15 (PC) SHALL never forward; ForwardXE=00 when the source is 15.
REQ-015 ldrStall SHALL be E.valid and E.MemToReg and E.RegWrite and (RA1D==E.WA3 or RA2D==E.WA3).
REQ-016 pcPend SHALL be PCSrcD or E.PCSrc or M.PCSrc.
REQ-017 Outputs SHALL be combinational from state and inputs:
- StallD = ldrStall and not BranchTakenE.
- StallF = (ldrStall or pcPend) and not BranchTakenE.
- FlushE = ldrStall or BranchTakenE.
- FlushD = pcPend or W.PCSrc or BranchTakenE.
REQ-018 On simultaneous ldrStall and BranchTakenE, the branch SHALL win: no stall, FlushD=FlushE=1.
REQ-019 StallCount SHALL increment by 1 on every rising edge where StallD=1, and SHALL saturate at 16'hFFFF (no wrap).
REQ-020 Forwarding and stall outputs SHALL have zero-cycle latency from their inputs and shadow state.

Reset
REQ-021 On a reset edge, E, M and W SHALL all become bubbles, and StallCount SHALL become 0.
REQ-022 While reset is high, all outputs SHALL read 0 (ForwardAE=ForwardBE=00), regardless of inputs.
REQ-023 Reset asserted mid-stall SHALL discard the stall; the first post-reset cycle SHALL see empty shadow stages.

Structure
REQ-024 Package arm_hazard_pkg SHALL hold the shared definitions used with the execute stage:
- fwd_sel_t enum (FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
- stage_rec_t struct.
- REG_PC=4'd15.
REQ-025 A sub-module hazard_stage_reg (one clocked stage_rec_t register with load/hold/bubble controls) SHALL be instantiated for E, M and W.

Verification
REQ-026 Forward from M: ADD R1 (RegWriteD=1, WA3D=1), then next instr RA1D=1 -> one cycle later ForwardAE=10, ForwardBE=00.
REQ-027 Forward from W with M priority: R2 written by two consecutive instrs, consumer RA2D=2 -> ForwardBE=10 (the younger M copy), not 01; with one gap instr -> 01.
REQ-028 Load-use: LDR R3 (MemToRegD=1), next instr RA1D=3 -> exactly one cycle of StallF=StallD=FlushE=1, then ForwardAE=01; StallCount increments 0->1.
REQ-029 Branch vs load-use: ldrStall condition and BranchTakenE=1 same cycle -> StallF=StallD=0, FlushD=FlushE=1, StallCount unchanged.
REQ-030 PC write: PCSrcD=1 for one instr -> FlushD=1 for 4 consecutive cycles and StallF=1 for 3; R15 source never forwards.
REQ-031 Saturation/reset: force 70000 stall cycles -> StallCount=16'hFFFF held; assert reset -> next edge StallCount=0 and all outputs 0.
